// File: rtl/hazard_pkg.sv
// Shared types for the pipeline sequencing controller: forwarding selects,
// scoreboard slot layout and the operand-forwarding priority function.
package hazard_pkg;

  localparam int REGW = 4;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic            vld;
    logic [REGW-1:0] rd;
    logic            wr;
    logic            ld;
    logic            pcw;
  } sb_slot_t;

  // Memory-stage producer beats Writeback-stage producer (younger result).
  function automatic fwd_sel_t fwd_sel(input sb_slot_t m, input sb_slot_t w,
                                       input logic [REGW-1:0] ra, input logic use_src);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_src && m.vld && m.wr && (m.rd == ra)) sel = FWD_M;
    else if (use_src && w.vld && w.wr && (w.rd == ra)) sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sb.sv
// E/M/W scoreboard: tracks what the datapath holds in each later stage so the
// controller only needs Decode-stage information from the datapath.
module hazard_sb
  import hazard_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            bubble_e,
  input  sb_slot_t        slot_d,
  input  logic [REGW-1:0] ra1_d,
  input  logic [REGW-1:0] ra2_d,
  input  logic            use1_d,
  input  logic            use2_d,
  output sb_slot_t        slot_e,
  output sb_slot_t        slot_m,
  output sb_slot_t        slot_w,
  output logic [REGW-1:0] ra1_e,
  output logic [REGW-1:0] ra2_e,
  output logic            use1_e,
  output logic            use2_e
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_e <= '0;
      slot_m <= '0;
      slot_w <= '0;
      ra1_e  <= '0;
      ra2_e  <= '0;
      use1_e <= 1'b0;
      use2_e <= 1'b0;
    end else if (hold) begin
      // Memory is busy: E and M keep their contents, W drains to a bubble.
      slot_w <= '0;
    end else begin
      slot_w <= slot_m;
      slot_m <= slot_e;
      if (bubble_e) begin
        slot_e <= '0;
        ra1_e  <= '0;
        ra2_e  <= '0;
        use1_e <= 1'b0;
        use2_e <= 1'b0;
      end else begin
        slot_e <= slot_d;
        ra1_e  <= ra1_d;
        ra2_e  <= ra2_d;
        use1_e <= use1_d;
        use2_e <= use2_d;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage F/D/E/M/W pipe, with a
// saturating count of cycles in which the PC is held.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] Ra1D,
  input  logic [REGW-1:0] Ra2D,
  input  logic            Use1D,
  input  logic            Use2D,
  input  logic [REGW-1:0] RdD,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            PCSrcD,
  input  logic            BranchTakenE,
  input  logic            MemBusyM,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushW,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [CNTW-1:0] StallCount
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  sb_slot_t        slot_d, slot_e, slot_m, slot_w;
  logic [REGW-1:0] ra1_e, ra2_e;
  logic            use1_e, use2_e;
  logic            ldstall, pcpend, pc_w;
  logic            unused_fields;

  assign slot_d = '{vld: 1'b1, rd: RdD, wr: RegWriteD, ld: MemtoRegD, pcw: PCSrcD};

  hazard_sb u_sb (
    .clk      (clk),
    .reset    (reset),
    .hold     (MemBusyM),
    .bubble_e (FlushE),
    .slot_d   (slot_d),
    .ra1_d    (Ra1D),
    .ra2_d    (Ra2D),
    .use1_d   (Use1D),
    .use2_d   (Use2D),
    .slot_e   (slot_e),
    .slot_m   (slot_m),
    .slot_w   (slot_w),
    .ra1_e    (ra1_e),
    .ra2_e    (ra2_e),
    .use1_e   (use1_e),
    .use2_e   (use2_e)
  );

  assign ForwardAE = fwd_sel(slot_m, slot_w, ra1_e, use1_e);
  assign ForwardBE = fwd_sel(slot_m, slot_w, ra2_e, use2_e);

  // A taken branch squashes the dependent instruction anyway, so no load stall.
  assign ldstall = slot_e.vld & slot_e.ld & ~BranchTakenE &
                   ((Use1D & (Ra1D == slot_e.rd)) | (Use2D & (Ra2D == slot_e.rd)));
  assign pcpend  = PCSrcD | (slot_e.vld & slot_e.pcw) | (slot_m.vld & slot_m.pcw);
  assign pc_w    = slot_w.vld & slot_w.pcw;

  assign unused_fields = &{1'b0, slot_e.wr, slot_m.ld, slot_w.ld};

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (MemBusyM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldstall | pcpend;
      StallD = ldstall;
      FlushD = pcpend | pc_w | BranchTakenE;
      FlushE = ldstall | BranchTakenE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) StallCount <= '0;
    else if (StallF && (StallCount != CNT_MAX)) StallCount <= StallCount + 1'b1;
  end

endmodule
